// File: rtl/ad9228_pkg.sv
// Shared types and constants for the AD9228 serial stream emulator.
package ad9228_pkg;

    // Word source selection, sampled on each load cycle.
    typedef enum logic [1:0] {
        MODE_STREAM  = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_FIXED   = 2'd3
    } mode_e;

    // Transmitter control state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Checkerboard constants: the first checker word has its MSB set
    // and alternates towards the LSB (0xAAA for a 12-bit frame).
    localparam int   CHECKER_MAX_WIDTH = 32;
    localparam logic CHECKER_MSB       = 1'b1;

    function automatic logic [CHECKER_MAX_WIDTH-1:0] checker_word(input int width);
        logic [CHECKER_MAX_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < CHECKER_MAX_WIDTH; i++) begin
            if (i < width) begin
                w[i] = (((width - 1 - i) % 2) == 0) ? CHECKER_MSB : ~CHECKER_MSB;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/ad9228_pattern_gen.sv
// Word source for the serializer: stream pass-through with a held copy
// for underruns, checkerboard, ramp and fixed word. State advances only
// on a load strobe; `clear` marks the load that enters RUN from IDLE.
module ad9228_pattern_gen
    import ad9228_pkg::*;
#(
    parameter int                    DATA_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 12'h800
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic                  clear,
    input  mode_e                 mode,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam logic [DATA_WIDTH-1:0] CHK_HI = DATA_WIDTH'(checker_word(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] CHK_LO = ~CHK_HI;

    logic [DATA_WIDTH-1:0] held_q;
    logic [DATA_WIDTH-1:0] ramp_q;
    logic                  chk_q;
    logic [DATA_WIDTH-1:0] ramp_cur;
    logic                  chk_cur;

    // On RUN entry the pattern state restarts, including for the entry load itself.
    assign ramp_cur = clear ? '0 : ramp_q;
    assign chk_cur  = clear ? 1'b0 : chk_q;

    // Word mux for the current load cycle.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        word = IDLE_WORD;
        case (mode)
            MODE_STREAM:  word = s_valid ? s_data : held_q;
            MODE_CHECKER: word = chk_cur ? CHK_LO : CHK_HI;
            MODE_RAMP:    word = ramp_cur;
            MODE_FIXED:   word = IDLE_WORD;
            default:      word = IDLE_WORD;
        endcase
    end

    // Pattern state update on each load.
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            held_q <= '0;
            ramp_q <= '0;
            chk_q  <= 1'b0;
        end else if (load) begin
            ramp_q <= ramp_cur;
            chk_q  <= chk_cur;
            case (mode)
                MODE_STREAM:  if (s_valid) held_q <= s_data;
                MODE_CHECKER: chk_q  <= ~chk_cur;
                MODE_RAMP:    ramp_q <= ramp_cur + 1'b1;
                default:      ;
            endcase
        end
    end

endmodule

// File: rtl/ad9228_serial_tx.sv
// AD9228-style single-lane serial transmitter: MSB-first data on din,
// frame clock fco (high for the first half of each frame) and bit clock
// dco with one edge centred in every bit. Frames run back to back.
module ad9228_serial_tx
    import ad9228_pkg::*;
#(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    BIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 12'h800
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  din,
    output logic                  fco,
    output logic                  dco,
    output logic                  frame_start,
    output logic                  underrun,
    output logic [15:0]           underrun_count
);

    localparam int PH_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BI_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(BIT_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_TOGGLE = PH_W'(BIT_CYCLES / 2 - 1);
    localparam logic [BI_W-1:0] BI_LAST   = BI_W'(DATA_WIDTH - 1);
    localparam logic [BI_W-1:0] BI_HALF   = BI_W'(DATA_WIDTH / 2);

    state_e                state_q;
    state_e                state_d;
    logic [PH_W-1:0]       ph_q;
    logic [BI_W-1:0]       bi_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] word;
    mode_e                 mode_sel;
    logic                  frame_last;
    logic                  load;
    logic                  entry;
    logic                  stream_load;

    assign mode_sel    = mode_e'(mode);
    assign frame_last  = (state_q == ST_RUN) && (ph_q == PH_LAST) && (bi_q == BI_LAST);
    assign stream_load = load && (mode_sel == MODE_STREAM);
    // Handshake is combinational on the load cycle; held low while in reset.
    assign s_ready     = rstn && stream_load;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and load-cycle decode; a frame always runs to its last cycle.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        entry   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    load    = 1'b1;
                    entry   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_last) begin
                    if (en) load    = 1'b1;
                    else    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ad9228_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDLE_WORD  (IDLE_WORD)
    ) u_gen (
        .clk     (clk),
        .rstn    (rstn),
        .load    (load),
        .clear   (entry),
        .mode    (mode_sel),
        .s_data  (s_data),
        .s_valid (s_valid),
        .word    (word)
    );

    // Phase and bit-index counters describe the bit currently on din.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph_q <= '0;
            bi_q <= '0;
        end else if (load || state_d == ST_IDLE) begin
            ph_q <= '0;
            bi_q <= '0;
        end else if (ph_q == PH_LAST) begin
            ph_q <= '0;
            bi_q <= bi_q + 1'b1;
        end else begin
            ph_q <= ph_q + 1'b1;
        end
    end

    // Serial data and frame clock: new bit registered one cycle after the
    // load, then at every bit boundary.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q     <= '0;
            din         <= 1'b0;
            fco         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= load;
            if (load) begin
                shift_q <= word << 1;
                din     <= word[DATA_WIDTH-1];
                fco     <= 1'b1;
            end else if (state_d == ST_IDLE) begin
                din <= 1'b0;
                fco <= 1'b0;
            end else if (ph_q == PH_LAST) begin
                shift_q <= shift_q << 1;
                din     <= shift_q[DATA_WIDTH-1];
                fco     <= (bi_q + 1'b1) < BI_HALF;
            end
        end
    end

    // Bit clock toggles mid-bit; an even count per frame leaves it low at frame start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dco <= 1'b0;
        end else if (state_d == ST_IDLE) begin
            dco <= 1'b0;
        end else if (state_q == ST_RUN && ph_q == PH_TOGGLE) begin
            dco <= ~dco;
        end
    end

    // Underrun pulse and saturating count for stream loads without a word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            underrun <= stream_load && !s_valid;
            if (stream_load && !s_valid && underrun_count != 16'hFFFF) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ad9228_serial_tx.sv
// Directed bench for ad9228_serial_tx (12-bit frames, 2 clk per bit).
module tb_ad9228_serial_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] s_data = 12'h000;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        din;
    logic        fco;
    logic        dco;
    logic        frame_start;
    logic        underrun;
    logic [15:0] underrun_count;

    int n_checks = 0;
    int n_errors = 0;

    ad9228_serial_tx #(
        .DATA_WIDTH (12),
        .BIT_CYCLES (2),
        .IDLE_WORD  (12'h800)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .mode           (mode),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .din            (din),
        .fco            (fco),
        .dco            (dco),
        .frame_start    (frame_start),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Vector {din, fco, dco, frame_start, s_ready, underrun} must be all zero.
    task automatic check_idle(input string tag);
        check(tag, {din, fco, dco, frame_start, s_ready, underrun}, 6'b0);
    endtask

    // Checks one 24-cycle frame starting at its first cycle (k = 0).
    // drop_at >= 0 clears en at that cycle index.
    task automatic check_frame(input string tag, input logic [11:0] w,
                               input logic ready_end, input logic ur_first,
                               input int drop_at);
        logic [5:0] exp;
        for (int k = 0; k < 24; k++) begin
            if (k == drop_at) en = 1'b0;
            #1;
            exp[5] = w[11 - k / 2];
            exp[4] = (k / 2) < 6;
            exp[3] = (((k + 1) / 2) % 2) == 1;
            exp[2] = (k == 0);
            exp[1] = (k == 23) && ready_end;
            exp[0] = (k == 0) && ur_first;
            check($sformatf("%s k%0d {din,fco,dco,fs,rdy,ur}", tag, k),
                  {din, fco, dco, frame_start, s_ready, underrun}, exp);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // 1: reset holds everything low while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            en      = i[0];
            mode    = 2'd0;
            s_valid = 1'b1;
            s_data  = 12'($urandom);
            #1;
            check_idle($sformatf("t1 in reset %0d", i));
            check($sformatf("t1 count in reset %0d", i), underrun_count, 16'd0);
            step();
        end
        en      = 1'b0;
        s_valid = 1'b0;
        rstn    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("t1 idle after release %0d", i));
        end

        // 2: stream 0xA5C then 0x3F1 back to back.
        mode    = 2'd0;
        s_data  = 12'hA5C;
        s_valid = 1'b1;
        en      = 1'b1;
        #1;
        check("t2 s_ready on first load", s_ready, 1'b1);
        step();
        s_data = 12'h3F1;
        check_frame("t2 A5C", 12'hA5C, 1'b1, 1'b0, -1);
        s_data = 12'h123;
        check_frame("t2 3F1", 12'h3F1, 1'b1, 1'b0, -1);

        // 3: underrun repeats the held word and counts; count saturates.
        s_valid = 1'b0;
        check_frame("t3 123", 12'h123, 1'b1, 1'b0, -1);
        s_valid = 1'b1;
        s_data  = 12'h0F0;
        check_frame("t3 123 repeat", 12'h123, 1'b1, 1'b1, -1);
        check("t3 count after one underrun", underrun_count, 16'd1);
        force dut.underrun_count = 16'hFFFF;
        #1;
        release dut.underrun_count;
        s_valid = 1'b0;
        check_frame("t3 0F0", 12'h0F0, 1'b1, 1'b0, -1);
        mode = 2'd2;
        check_frame("t3 0F0 repeat", 12'h0F0, 1'b0, 1'b1, -1);
        check("t3 count saturated", underrun_count, 16'hFFFF);

        // 4: ramp from 0, jump near the top to show the wrap, then checker.
        check_frame("t4 ramp 000", 12'h000, 1'b0, 1'b0, -1);
        check_frame("t4 ramp 001", 12'h001, 1'b0, 1'b0, -1);
        force dut.u_gen.ramp_q = 12'hFFE;
        #1;
        release dut.u_gen.ramp_q;
        check_frame("t4 ramp 002", 12'h002, 1'b0, 1'b0, -1);
        check_frame("t4 ramp FFE", 12'hFFE, 1'b0, 1'b0, -1);
        check_frame("t4 ramp FFF", 12'hFFF, 1'b0, 1'b0, -1);
        mode = 2'd1;
        check_frame("t4 ramp wrap 000", 12'h000, 1'b0, 1'b0, -1);
        check_frame("t4 chk AAA", 12'hAAA, 1'b0, 1'b0, -1);
        check_frame("t4 chk 555", 12'h555, 1'b0, 1'b0, -1);

        // 5: drop en at bi = 5; frame completes, then idle.
        check_frame("t5 chk AAA drop", 12'hAAA, 1'b0, 1'b0, 10);
        mode    = 2'd0;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_idle($sformatf("t5 idle %0d", i));
            step();
        end
        mode = 2'd2;
        en   = 1'b1;
        #1;
        check("t5 s_ready ramp load", s_ready, 1'b0);
        step();
        check_frame("t5 ramp restart", 12'h000, 1'b0, 1'b0, -1);

        // 6: reset at bi = 7 clears outputs at once; restart in fixed mode.
        repeat (14) step();
        rstn = 1'b0;
        #1;
        check_idle("t6 outputs in mid-frame reset");
        check("t6 count in reset", underrun_count, 16'd0);
        en   = 1'b1;
        mode = 2'd3;
        step();
        step();
        rstn = 1'b1;
        #1;
        check("t6 s_ready fixed load", s_ready, 1'b0);
        step();
        check_frame("t6 fixed 800", 12'h800, 1'b0, 1'b0, -1);
        en = 1'b0;
        check_frame("t6 fixed 800 last", 12'h800, 1'b0, 1'b0, -1);
        check_idle("t6 idle at end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
